if0_fetch_gen: RTL
==================

# if0_fetch_gen

Parametrised instruction-fetch address generator with decoupling queue; first stage of the front end. Produces one fetch-block request per cycle to the I-cache, steers the next PC from the BPU, and buffers accepted requests with per-lane predecode (valid/taken masks, exception) for IF1. Unlike a single-register IF0, it fetches FETCH_WIDTH instructions per block, tolerates IF1 back-pressure through a QDEPTH-entry queue, and halts cleanly on address exceptions until redirected.

## Interface
- RESET_PC, 32'h1c000000, PC loaded on reset
- FETCH_WIDTH, 4, instructions per fetch block (1, 2, 4 or 8)
- QDEPTH, 4, request queue entries (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  jump/flush from back end; highest priority
- redirect_pc  in  32  redirect target
- req_valid  out  1  fetch request to I-cache
- req_addr  out  32  fetch address (current PC)
- req_uncached  out  1  tied 0
- req_addr_ok  in  1  cache accepts request this cycle
- bpu_pc  out  32  equals req_addr
- bpu_next_pc  in  32  predicted next block PC
- bpu_valid_mask  in  FETCH_WIDTH  lanes the BPU marks valid
- bpu_taken_mask  in  FETCH_WIDTH  lanes predicted taken
- out_valid  out  1  queue head valid to IF1
- out_ready  in  1  IF1 accepts head
- out_pc  out  32  head PC
- out_valid_mask, out_taken_mask  out  FETCH_WIDTH  head lane masks
- out_excp  out  1  head carries exception
- out_ecode  out  6  6'h8 (ADEF) when out_excp, else 0
- out_subecode  out  9  always 0

## Operation
- State: RUN, HALT. Reset → RUN, PC=RESET_PC, queue empty.
- Lane offset = PC[$clog2(FETCH_WIDTH)+1:2]; align_mask sets lanes ≥ offset. Entry valid_mask = align_mask & bpu_valid_mask; taken_mask = bpu_taken_mask & valid_mask.
- ADEF = |PC[1:0].
- req_valid = RUN & ~ADEF & ~redirect_valid & (count < QDEPTH).
- Accept (req_valid & req_addr_ok): push {0, 0, 0, valid_mask, taken_mask, PC}; PC ← bpu_next_pc.
- No accept: PC holds.
- RUN & ADEF & count<QDEPTH & ~redirect_valid: push {excp=1, ecode=6'h8, subecode=0, masks=0, PC}, no cache request, → HALT. PC holds.
- HALT: no requests, no pushes; queue drains normally.
- redirect_valid (any state): PC ← redirect_pc, queue cleared (count=0, pointers reset), → RUN; no push and no pop that cycle, regardless of req_addr_ok/out_ready.
- Pop when out_valid & out_ready. out_valid = count≠0. Head fields driven combinationally from queue storage.
- Full: push permitted only when count<QDEPTH at start of cycle (simultaneous pop does not free a slot that cycle). Empty: pop impossible.
- Pointers wrap modulo QDEPTH; count width $clog2(QDEPTH)+1.
- Simultaneous push and pop: count unchanged.

## Timing
- Reset values: req_valid 0, req_addr RESET_PC, out_valid 0, out_* fields 0, state RUN.
- Request accepted in cycle N → entry visible at out_* in cycle N+1 (if queue was empty).
- Accept in N → req_addr = bpu_next_pc(N) in N+1; one block per cycle sustained with addr_ok and out_ready high.
- redirect in N → req_addr = redirect_pc and out_valid=0 in N+1; req_valid low in N.
- ADEF PC in N → excp entry visible N+1, req_valid stays 0 from N until redirect.
- Reset asserted mid-operation overrides redirect and all handshakes; takes effect next edge.

## Structure
- Package if_pkg: ECODE_ADEF=6'h8, fetch-entry struct (excp, ecode, subecode, valid_mask, taken_mask, pc) parametrised by FETCH_WIDTH, state enum {RUN, HALT}.
- Sub-module fetch_queue: synchronous FIFO (QDEPTH × entry width, push/pop/clear, count, full/empty). PC/state logic in the top.

## Test plan
- Reset, addr_ok=1, out_ready=1, bpu_next_pc=PC+16, FW=4 → req_addr 1c000000, 1c000010, 1c000020…; out_pc same sequence one cycle later, valid_mask 4'b1111.
- out_ready=0, addr_ok=1, QDEPTH=4 → exactly 4 accepts, req_valid drops, PC holds at 1c000040; out_ready=1 → pops resume, fetch restarts after first pop cycle.
- redirect_valid with redirect_pc=1c000108 while queue holds 3 → next cycle out_valid=0, req_addr=1c000108, valid_mask lanes 2,3 only (4'b1100).
- redirect_pc=1c000102 → no cache request; one entry out_excp=1, out_ecode=6'h8, masks 0; req_valid stays 0 until redirect to 1c000200 resumes fetch.
- addr_ok=0 for 3 cycles → req_addr stable, no pushes; bpu_taken_mask=4'b0010 on next accept → out_taken_mask 4'b0010.
- rst asserted mid-stream with redirect_valid=1 → next cycle PC=1c000000, out_valid=0, req_valid=1.

Source files
------------

// File: rtl/if0_fetch_gen_pkg.sv
// Shared types for the IF0 fetch-address generator.
// Queue entries carry lane masks sized for the widest supported fetch block.
package if_pkg;

    localparam logic [5:0] ECODE_ADEF = 6'h8;

    // Widest fetch block supported.
    // Narrower configurations use the low FETCH_WIDTH lanes.
    localparam int FW_MAX = 8;

    typedef struct packed {
        logic              excp;
        logic [5:0]        ecode;
        logic [8:0]        subecode;
        logic [FW_MAX-1:0] valid_mask;
        logic [FW_MAX-1:0] taken_mask;
        logic [31:0]       pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if0_fetch_gen_fetch_queue.sv
// Synchronous FIFO that decouples IF0 requests from IF1 consumption.
// The clear input flushes every entry on a redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign dout    = mem[rd_ptr];

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if0_fetch_gen.sv
// IF0: fetch-block address generator with a decoupling request queue.
// Steers the PC from the BPU, halts on a misaligned PC until redirected.
module if0_fetch_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          FETCH_WIDTH = 4,
    parameter int          QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   req_valid,
    output logic [31:0]            req_addr,
    output logic                   req_uncached,
    input  logic                   req_addr_ok,
    output logic [31:0]            bpu_pc,
    input  logic [31:0]            bpu_next_pc,
    input  logic [FETCH_WIDTH-1:0] bpu_valid_mask,
    input  logic [FETCH_WIDTH-1:0] bpu_taken_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [FETCH_WIDTH-1:0] out_valid_mask,
    output logic [FETCH_WIDTH-1:0] out_taken_mask,
    output logic                   out_excp,
    output logic [5:0]             out_ecode,
    output logic [8:0]             out_subecode
);

    localparam int OW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t     state;
    logic [31:0]      pc;
    logic             adef;
    logic             run_ok;
    logic             push_fetch;
    logic             push_excp;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic [CW-1:0]    q_count;
    logic [OW-1:0]    lane_off;
    logic [FETCH_WIDTH-1:0] align_mask;
    logic [FETCH_WIDTH-1:0] valid_mask;
    logic [FETCH_WIDTH-1:0] taken_mask;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [ENTRY_W-1:0] q_dout;
    logic             unused_hi;

    assign adef   = |pc[1:0];
    assign run_ok = ~rst & ~redirect_valid & (state == RUN) & ~q_full;

    assign req_valid    = run_ok & ~adef;
    assign req_addr     = pc;
    assign req_uncached = 1'b0;
    assign bpu_pc       = pc;

    assign push_fetch = req_valid & req_addr_ok;
    assign push_excp  = run_ok & adef;
    assign pop        = out_valid & out_ready & ~redirect_valid & ~rst;

    assign lane_off = (FETCH_WIDTH > 1) ? pc[OW+1:2] : '0;

    // Lanes before the PC's slot within the block are not fetched.
    always_comb begin
        align_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            align_mask[i] = (i >= int'(lane_off));
        end
    end

    assign valid_mask = align_mask & bpu_valid_mask;
    assign taken_mask = bpu_taken_mask & valid_mask;

    // Build the entry pushed this cycle: normal block or ADEF marker.
    always_comb begin
        push_entry    = '0;
        push_entry.pc = pc;
        if (adef) begin
            push_entry.excp  = 1'b1;
            push_entry.ecode = ECODE_ADEF;
        end else begin
            push_entry.valid_mask = FW_MAX'(valid_mask);
            push_entry.taken_mask = FW_MAX'(taken_mask);
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push_fetch | push_excp),
        .pop   (pop),
        .clear (redirect_valid),
        .din   (push_entry),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head      = q_dout;
    assign out_valid = ~q_empty;

    // Head fields read as zero while the queue is empty.
    assign out_pc         = out_valid ? head.pc : '0;
    assign out_valid_mask = out_valid ? head.valid_mask[FETCH_WIDTH-1:0] : '0;
    assign out_taken_mask = out_valid ? head.taken_mask[FETCH_WIDTH-1:0] : '0;
    assign out_excp       = out_valid & head.excp;
    assign out_ecode      = out_valid ? head.ecode : '0;
    assign out_subecode   = out_valid ? head.subecode : '0;

    assign unused_hi = ^{head.valid_mask, head.taken_mask, q_count};

    // PC and run/halt state; redirect beats fetch, reset beats all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else if (redirect_valid) begin
            state <= RUN;
            pc    <= redirect_pc;
        end else if (push_fetch) begin
            pc    <= bpu_next_pc;
        end else if (push_excp) begin
            state <= HALT;
        end
    end

endmodule
